pc_redirect_unit: RTL and testbench



---
 rtl/pc_redirect_unit.sv | 166 ++++++++++++++++
 tb/tb_pc_redirect_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_unit
// Description : Fetch-stage PC register with sequential advance and an
//               N-channel priority redirect selector. A redirect that arrives
//               under stall is parked and applied when the stall releases.
//               Optional macro PC_ALIGN_CHECK_EN: force-align loaded targets
//               and pulse align_fault.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_redirect_unit #(
    parameter int              WIDTH        = 32,
    parameter int              NUM_SRC      = 4,
    parameter int              STEP         = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic [NUM_SRC-1:0]       redir_valid,
    input  logic [NUM_SRC*WIDTH-1:0] redir_target,
    output logic [WIDTH-1:0]         pc,
    output logic                     redir_taken,
    output logic [2:0]               redir_src,
    output logic                     pend_valid,
    output logic                     align_fault
);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_pend_tgt;
    logic [2:0]       r_pend_src;
    logic             r_taken;
    logic [2:0]       r_src;
    logic             r_fault;

    logic             w_any;
    logic [2:0]       w_sel;
    logic [WIDTH-1:0] w_sel_tgt;

    logic             w_load;
    logic             w_capture;
    logic [WIDTH-1:0] w_load_raw;
    logic [2:0]       w_load_src;
    logic [WIDTH-1:0] w_load_tgt;
    logic             w_misalign;
    logic [WIDTH-1:0] w_pc_nxt;

    // Walk from lowest priority upward so the last hit is the winner.
    always_comb begin
        w_any     = 1'b0;
        w_sel     = '0;
        w_sel_tgt = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (redir_valid[i]) begin
                w_any     = 1'b1;
                w_sel     = 3'(i);
                w_sel_tgt = redir_target[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        w_load_raw  = '0;
        w_load_src  = '0;
        case (r_state)
            S_RUN: begin
                if (!stall) begin
                    if (w_any) begin
                        w_load     = 1'b1;
                        w_load_raw = w_sel_tgt;
                        w_load_src = w_sel;
                    end
                end else if (w_any) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (stall) begin
                    // Equal index overwrites so the freshest target of a channel wins.
                    w_capture = w_any && (w_sel <= r_pend_src);
                end else begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                    if (w_any && (w_sel < r_pend_src)) begin
                        w_load_raw = w_sel_tgt;
                        w_load_src = w_sel;
                    end else begin
                        w_load_raw = r_pend_tgt;
                        w_load_src = r_pend_src;
                    end
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [WIDTH-1:0] c_align_mask = WIDTH'(STEP - 1);
    assign w_load_tgt = w_load_raw & ~c_align_mask;
    assign w_misalign = |(w_load_raw & c_align_mask);
`else
    assign w_load_tgt = w_load_raw;
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_pc_nxt = r_pc;
        if (w_load) begin
            w_pc_nxt = w_load_tgt;
        end else if ((r_state == S_RUN) && !stall) begin
            w_pc_nxt = r_pc + WIDTH'(STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_VECTOR;
            r_pend_tgt <= '0;
            r_pend_src <= '0;
            r_taken    <= 1'b0;
            r_src      <= '0;
            r_fault    <= 1'b0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_taken <= w_load;
            r_fault <= w_load & w_misalign;
            if (w_capture) begin
                r_pend_tgt <= w_sel_tgt;
                r_pend_src <= w_sel;
            end
            if (w_load) begin
                r_src <= w_load_src;
            end
        end
    end

    assign pc          = r_pc;
    assign redir_taken = r_taken;
    assign redir_src   = r_src;
    assign pend_valid  = (r_state == S_HOLD);
    assign align_fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_pc_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_redirect_unit
// Description : Directed scoreboard bench for pc_redirect_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_redirect_unit;

    logic         clk = 1'b0;
    logic         reset;
    logic         stall;
    logic [3:0]   redir_valid;
    logic [127:0] redir_target;
    logic [31:0]  pc;
    logic         redir_taken;
    logic [2:0]   redir_src;
    logic         pend_valid;
    logic         align_fault;

    int checks   = 0;
    int failures = 0;
    bit done     = 1'b0;

    typedef struct packed {
        logic [31:0] pc;
        logic        pend;
        logic        taken;
        logic [2:0]  src;
        logic        fault;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    pc_redirect_unit #(
        .WIDTH       (32),
        .NUM_SRC     (4),
        .STEP        (4),
        .RESET_VECTOR(32'h0000_0100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redir_valid (redir_valid),
        .redir_target(redir_target),
        .pc          (pc),
        .redir_taken (redir_taken),
        .redir_src   (redir_src),
        .pend_valid  (pend_valid),
        .align_fault (align_fault)
    );

    // Inputs are applied 1 time unit after an edge; the expected state after
    // the following edge goes into the scoreboard.
    task automatic drive(input logic rs, input logic st, input logic [3:0] v,
                         input logic [31:0] t0, input logic [31:0] t1,
                         input logic [31:0] t2, input logic [31:0] t3,
                         input logic [31:0] e_pc, input logic e_pend,
                         input logic e_taken, input logic [2:0] e_src,
                         input logic e_fault);
        exp_t e;
        reset        = rs;
        stall        = st;
        redir_valid  = v;
        redir_target = {t3, t2, t1, t0};
        e.pc    = e_pc;
        e.pend  = e_pend;
        e.taken = e_taken;
        e.src   = e_src;
        e.fault = e_fault;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every edge the DUT presents a new state, 2 units after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (pc !== e.pc || pend_valid !== e.pend || redir_taken !== e.taken ||
                    align_fault !== e.fault || (e.taken && redir_src !== e.src)) begin
                    failures++;
                    $display("FAIL state #%0d: got pc=%h pend=%b taken=%b src=%0d fault=%b, want pc=%h pend=%b taken=%b src=%0d fault=%b",
                             checks, pc, pend_valid, redir_taken, redir_src, align_fault,
                             e.pc, e.pend, e.taken, e.src, e.fault);
                end
            end
        end
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL timeout: bench still running at time %0t, required finish", $time);
            $fatal(1, "timeout");
        end
    end

    localparam logic [31:0] Z = 32'h0;
`ifdef PC_ALIGN_CHECK_EN
    localparam logic [31:0] ALN_PC    = 32'h0000_1000;
    localparam logic        ALN_FAULT = 1'b1;
`else
    localparam logic [31:0] ALN_PC    = 32'h0000_1002;
    localparam logic        ALN_FAULT = 1'b0;
`endif

    initial begin
        // Reset and free-running sequence
        drive(1, 0, 4'b0000, Z, Z, Z, Z, 32'h100, 0, 0, 0, 0);
        drive(1, 1, 4'b1111, 32'hAAA0, Z, Z, Z, 32'h100, 0, 0, 0, 0);
        drive(0, 0, 4'b0000, Z, Z, Z, Z, 32'h104, 0, 0, 0, 0);
        drive(0, 0, 4'b0000, Z, Z, Z, Z, 32'h108, 0, 0, 0, 0);
        drive(0, 0, 4'b0000, Z, Z, Z, Z, 32'h10C, 0, 0, 0, 0);
        // Priority redirect, no stall
        drive(0, 0, 4'b0110, Z, 32'h2000, 32'h3000, Z, 32'h2000, 0, 1, 1, 0);
        drive(0, 0, 4'b0000, Z, Z, Z, Z, 32'h2004, 0, 0, 0, 0);
        // Redirect under stall, held three cycles
        drive(0, 1, 4'b1000, Z, Z, Z, 32'h4000, 32'h2004, 1, 0, 0, 0);
        drive(0, 1, 4'b0000, Z, Z, Z, Z, 32'h2004, 1, 0, 0, 0);
        drive(0, 1, 4'b0000, Z, Z, Z, Z, 32'h2004, 1, 0, 0, 0);
        drive(0, 0, 4'b0000, Z, Z, Z, Z, 32'h4000, 0, 1, 3, 0);
        drive(0, 0, 4'b0000, Z, Z, Z, Z, 32'h4004, 0, 0, 0, 0);
        // Pending ch2 replaced by ch0; a later ch3 must not replace it
        drive(0, 1, 4'b0100, Z, Z, 32'h5000, Z, 32'h4004, 1, 0, 0, 0);
        drive(0, 1, 4'b0001, 32'h8000, Z, Z, Z, 32'h4004, 1, 0, 0, 0);
        drive(0, 1, 4'b1000, Z, Z, Z, 32'h9000, 32'h4004, 1, 0, 0, 0);
        drive(0, 0, 4'b0000, Z, Z, Z, Z, 32'h8000, 0, 1, 0, 0);
        // Release with a higher-priority live request
        drive(0, 1, 4'b0010, Z, 32'h6000, Z, Z, 32'h8000, 1, 0, 0, 0);
        drive(0, 0, 4'b0001, 32'h7000, Z, Z, Z, 32'h7000, 0, 1, 0, 0);
        // Release with a lower-priority live request: pending wins
        drive(0, 1, 4'b0100, Z, Z, 32'hA000, Z, 32'h7000, 1, 0, 0, 0);
        drive(0, 0, 4'b1000, Z, Z, Z, 32'hB000, 32'hA000, 0, 1, 2, 0);
        // Reset in HOLD discards the pending redirect
        drive(0, 1, 4'b0001, 32'hC000, Z, Z, Z, 32'hA000, 1, 0, 0, 0);
        drive(1, 1, 4'b0001, 32'hC000, Z, Z, Z, 32'h100, 0, 0, 0, 0);
        drive(0, 0, 4'b0000, Z, Z, Z, Z, 32'h104, 0, 0, 0, 0);
        // Wraparound
        drive(0, 0, 4'b0001, 32'hFFFF_FFFC, Z, Z, Z, 32'hFFFF_FFFC, 0, 1, 0, 0);
        drive(0, 0, 4'b0000, Z, Z, Z, Z, 32'h0, 0, 0, 0, 0);
        drive(0, 0, 4'b0000, Z, Z, Z, Z, 32'h4, 0, 0, 0, 0);
        // Misaligned target
        drive(0, 0, 4'b0010, Z, 32'h1002, Z, Z, ALN_PC, 0, 1, 1, ALN_FAULT);
        drive(0, 0, 4'b0000, Z, Z, Z, Z, ALN_PC + 32'h4, 0, 0, 0, 0);
        // Plain stall holds pc without entering HOLD
        drive(0, 1, 4'b0000, Z, Z, Z, Z, ALN_PC + 32'h4, 0, 0, 0, 0);
        drive(0, 0, 4'b0000, Z, Z, Z, Z, ALN_PC + 32'h8, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
